// File: rtl/ap_ctrl_txn_profiler.sv
// ap_ctrl_txn_profiler: per-transaction latency/interval/stall profiler on ap_ctrl with a record FIFO
// Define PROFILER_STALL_EN to measure ap_ready stalls; otherwise rec_stall is tied to 0.
module ap_ctrl_txn_profiler #(
  parameter int CNT_W      = 32,
  parameter int ID_W       = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] rec_stall,
  output logic [15:0]      overflow_cnt,
  output logic             proto_err,
  output logic             busy,
  output logic             drained
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, WAIT_CONT, FLUSH} state_t;
  state_t state, state_n, end_st;
  logic accept, take, done_push, push, pop, fin_pend, started;
  logic [CNT_W-1:0] lat, ivl, ivl_snap, push_lat, push_ivl;
  logic [ID_W-1:0] id;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [AW:0] cnt, cnt_n;
  logic [ID_W-1:0] id_m [FIFO_DEPTH];
  logic [CNT_W-1:0] lat_m [FIFO_DEPTH];
  logic [CNT_W-1:0] ivl_m [FIFO_DEPTH];
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction
  always_comb begin
    accept    = ap_start & ap_ready;
    take      = state == IDLE && !finish && accept;
    done_push = (take || state == RUN) && ap_done;
    push_lat  = take ? '0 : lat;
    push_ivl  = take ? ivl : ivl_snap;
    pop       = rec_valid & rec_ready;
    push      = done_push && (cnt != FULL || pop);
    rd_n      = pop ? rd_ptr + 1'b1 : rd_ptr;
    cnt_n     = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end_st    = (finish || fin_pend) ? FLUSH : IDLE;
    state_n   = state;
    case (state)
      IDLE:      state_n = finish ? FLUSH : !take ? IDLE : !ap_done ? RUN : ap_continue ? IDLE : WAIT_CONT;
      RUN:       state_n = !ap_done ? RUN : ap_continue ? end_st : WAIT_CONT;
      WAIT_CONT: state_n = ap_continue ? end_st : WAIT_CONT;
      default:   state_n = FLUSH;
    endcase
  end
`ifdef PROFILER_STALL_EN
  logic [CNT_W-1:0] stall, stall_snap, push_stall;
  logic [CNT_W-1:0] stall_m [FIFO_DEPTH];
  assign push_stall = take ? stall : stall_snap;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall      <= '0;
      stall_snap <= '0;
      rec_stall  <= '0;
    end else begin
      stall <= take ? '0 : (state == IDLE && ap_start && !ap_ready) ? sat(stall) : stall;
      if (take) stall_snap <= stall;
      if (cnt_n != 0) rec_stall <= (push && wr_ptr == rd_n) ? push_stall : stall_m[rd_n];
    end
  end
  always_ff @(posedge clock)
    if (push) stall_m[wr_ptr] <= push_stall;
`else
  assign rec_stall = '0;
`endif
  always_ff @(posedge clock)
    if (push) begin
      id_m[wr_ptr]  <= id;
      lat_m[wr_ptr] <= push_lat;
      ivl_m[wr_ptr] <= push_ivl;
    end
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      drained      <= 1'b0;
      fin_pend     <= 1'b0;
      proto_err    <= 1'b0;
      started      <= 1'b0;
      lat          <= '0;
      ivl          <= '0;
      ivl_snap     <= '0;
      id           <= '0;
      overflow_cnt <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      rec_valid    <= 1'b0;
      rec_id       <= '0;
      rec_latency  <= '0;
      rec_interval <= '0;
    end else begin
      state    <= state_n;
      busy     <= state_n == RUN || state_n == WAIT_CONT;
      drained  <= state == FLUSH && cnt == 0;
      fin_pend <= (state == RUN || state == WAIT_CONT) && (fin_pend || finish);
      if (accept && (state == RUN || state == WAIT_CONT)) proto_err <= 1'b1;
      // latency starts at 1 on accept so the value held at done equals done-accept
      lat <= take ? CNT_W'(1) : state == RUN ? sat(lat) : lat;
      ivl <= take ? CNT_W'(1) : started ? sat(ivl) : ivl;
      if (take) begin
        started  <= 1'b1;
        ivl_snap <= ivl;
      end
      if (done_push) id <= id + 1'b1;
      if (done_push && !push && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_n;
      cnt       <= cnt_n;
      rec_valid <= cnt_n != 0;
      // new head bypasses memory when the pushed record becomes the head
      if (cnt_n != 0) begin
        rec_id       <= (push && wr_ptr == rd_n) ? id : id_m[rd_n];
        rec_latency  <= (push && wr_ptr == rd_n) ? push_lat : lat_m[rd_n];
        rec_interval <= (push && wr_ptr == rd_n) ? push_ivl : ivl_m[rd_n];
      end
    end
  end
endmodule
